// File: rtl/gmii_pkg.sv
// Shared GMII constants, FSM state encoding and transmit beat payload.
package gmii_pkg;

  localparam logic [7:0]  GMII_PREAMBLE   = 8'h55;
  localparam logic [7:0]  GMII_SFD        = 8'hD5;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

  localparam int unsigned BYTE_CNT_W = 11;
  localparam int unsigned CYC_CNT_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    DATA,
    PAD,
    FCS,
    IFG
  } tx_state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       en;
    logic       er;
  } gmii_tx_t;

endpackage

// File: rtl/crc32_d8.sv
// Combinational bytewise reflected CRC-32 step (LSB of data first).
module crc32_d8
  import gmii_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out_c
);

  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    crc_out_c = c;
  end

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, payload, zero pad, CRC-32 FCS, inter-frame gap.
module gmii_tx_framer
  import gmii_pkg::*;
#(
  parameter int unsigned PREAMBLE_BYTES  = 7,
  parameter int unsigned MIN_FRAME_BYTES = 60,
  parameter int unsigned IFG_BYTES       = 12
) (
  input  logic       tx_clk,
  input  logic       tx_reset_n,
  input  logic       link_up,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  input  logic       s_error,
  output logic       s_ready,
  output logic [7:0] txd,
  output logic       tx_en,
  output logic       tx_er,
  output logic       frame_done,
  output logic       underrun
);

  tx_state_e             state, state_d;
  logic [CYC_CNT_W-1:0]  cyc_cnt, cyc_cnt_d;
  logic [BYTE_CNT_W-1:0] byte_cnt, byte_cnt_d;
  logic [31:0]           crc, crc_d, crc_next_c, fcs_c;
  logic [7:0]            crc_data;
  logic                  done_pend, done_pend_d;
  logic                  frame_done_d, underrun_d;
  logic                  byte_cnt_max;
  gmii_tx_t              tx_q, tx_d;

  crc32_d8 u_crc (
    .crc_in    (crc),
    .data      (crc_data),
    .crc_out_c (crc_next_c)
  );

  assign s_ready      = (state == DATA);
  assign byte_cnt_max = &byte_cnt;
  assign crc_data     = (state == DATA) ? s_data : 8'h00;
  assign fcs_c        = ~crc;

  // Next-state and next-output decode; outputs land on the pins one cycle later.
  always_comb begin
    state_d      = state;
    cyc_cnt_d    = cyc_cnt;
    byte_cnt_d   = byte_cnt;
    crc_d        = crc;
    done_pend_d  = 1'b0;
    tx_d         = '0;
    frame_done_d = 1'b0;
    underrun_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (s_valid && link_up) state_d = PRE;
      end
      PRE: begin
        tx_d.data = GMII_PREAMBLE;
        tx_d.en   = 1'b1;
        cyc_cnt_d = cyc_cnt + 1'b1;
        if (32'(cyc_cnt) + 32'd1 >= PREAMBLE_BYTES) begin
          cyc_cnt_d = '0;
          state_d   = SFD;
        end
      end
      SFD: begin
        tx_d.data = GMII_SFD;
        tx_d.en   = 1'b1;
        state_d   = DATA;
      end
      DATA: begin
        tx_d.en = 1'b1;
        if (s_valid) begin
          tx_d.data = s_data;
          tx_d.er   = s_error;
          crc_d     = crc_next_c;
          if (!byte_cnt_max) byte_cnt_d = byte_cnt + 1'b1;
          if (s_last) begin
            state_d = (32'(byte_cnt) + 32'd1 < MIN_FRAME_BYTES) ? PAD : FCS;
          end
        end else begin
          // Starved mid-frame: poison the frame in-band and drop the FCS.
          tx_d.er    = 1'b1;
          underrun_d = 1'b1;
          state_d    = IFG;
        end
      end
      PAD: begin
        tx_d.en = 1'b1;
        crc_d   = crc_next_c;
        if (!byte_cnt_max) byte_cnt_d = byte_cnt + 1'b1;
        if (32'(byte_cnt) + 32'd1 >= MIN_FRAME_BYTES) state_d = FCS;
      end
      FCS: begin
        tx_d.data = 8'(fcs_c >> {cyc_cnt[1:0], 3'b000});
        tx_d.en   = 1'b1;
        cyc_cnt_d = cyc_cnt + 1'b1;
        if (cyc_cnt[1:0] == 2'd3) begin
          cyc_cnt_d   = '0;
          done_pend_d = 1'b1;
          state_d     = IFG;
        end
      end
      IFG: begin
        crc_d        = CRC32_INIT;
        byte_cnt_d   = '0;
        frame_done_d = done_pend;
        cyc_cnt_d    = cyc_cnt + 1'b1;
        if (32'(cyc_cnt) + 32'd1 >= IFG_BYTES) begin
          cyc_cnt_d = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge tx_clk or negedge tx_reset_n) begin
    if (!tx_reset_n) begin
      state      <= IDLE;
      cyc_cnt    <= '0;
      byte_cnt   <= '0;
      crc        <= CRC32_INIT;
      done_pend  <= 1'b0;
      tx_q       <= '0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_d;
      cyc_cnt    <= cyc_cnt_d;
      byte_cnt   <= byte_cnt_d;
      crc        <= crc_d;
      done_pend  <= done_pend_d;
      tx_q       <= tx_d;
      frame_done <= frame_done_d;
      underrun   <= underrun_d;
    end
  end

  assign txd   = tx_q.data;
  assign tx_en = tx_q.en;
  assign tx_er = tx_q.er;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer: default instance plus a no-padding instance on shared stimulus.
module tb_gmii_tx_framer;

  typedef logic [7:0] bq_t[$];

  logic       tx_clk = 1'b0;
  logic       tx_reset_n = 1'b0;
  logic       link_up = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0, s_last = 1'b0, s_error = 1'b0;
  logic       s_ready, tx_en, tx_er, frame_done, underrun;
  logic [7:0] txd;
  logic       s_ready0, tx_en0, tx_er0, frame_done0, underrun0;
  logic [7:0] txd0;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  logic [8:0] cap[$];
  logic [8:0] cap0[$];
  int cap_cyc[$];
  int fd_cnt = 0, ur_cnt = 0, both_cnt = 0, fd0_cnt = 0, ur0_cnt = 0, fd_cyc = 0, ur_cyc = 0;

  gmii_tx_framer dut (
    .tx_clk(tx_clk), .tx_reset_n(tx_reset_n), .link_up(link_up),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_error(s_error),
    .s_ready(s_ready), .txd(txd), .tx_en(tx_en), .tx_er(tx_er),
    .frame_done(frame_done), .underrun(underrun)
  );

  gmii_tx_framer #(.MIN_FRAME_BYTES(0)) dut0 (
    .tx_clk(tx_clk), .tx_reset_n(tx_reset_n), .link_up(link_up),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_error(s_error),
    .s_ready(s_ready0), .txd(txd0), .tx_en(tx_en0), .tx_er(tx_er0),
    .frame_done(frame_done0), .underrun(underrun0)
  );

  always #4 tx_clk = ~tx_clk;
  always @(posedge tx_clk) cyc <= cyc + 1;

  always @(negedge tx_clk) begin
    if (tx_en) begin
      cap.push_back({tx_er, txd});
      cap_cyc.push_back(cyc);
    end
    if (tx_en0) cap0.push_back({tx_er0, txd0});
    if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
    if (underrun) begin ur_cnt++; ur_cyc = cyc; end
    if (frame_done && underrun) both_cnt++;
    if (frame_done0) fd0_cnt++;
    if (underrun0) ur0_cnt++;
  end

  function automatic logic [31:0] crc_model(input bq_t d);
    logic [31:0] c;
    logic fb;
    c = 32'hFFFFFFFF;
    foreach (d[k]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ d[k][b];
        c = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  function automatic bq_t build_frame(input bq_t pl, input int min_len);
    bq_t body, f;
    logic [31:0] fcs;
    body = pl;
    while (body.size() < min_len) body.push_back(8'h00);
    fcs = crc_model(body);
    for (int k = 0; k < 7; k++) f.push_back(8'h55);
    f.push_back(8'hD5);
    foreach (body[k]) f.push_back(body[k]);
    for (int k = 0; k < 4; k++) f.push_back(fcs[8*k +: 8]);
    return f;
  endfunction

  // Index of the first captured beat that differs from ex, -1 when all agree.
  function automatic int frame_diff(input bit sel, input int base, input bq_t ex, input int er_at);
    logic [8:0] got;
    foreach (ex[k]) begin
      if (sel) begin
        if (base + k >= cap0.size()) return k;
        got = cap0[base + k];
      end else begin
        if (base + k >= cap.size()) return k;
        got = cap[base + k];
      end
      if (got !== {(k == er_at), ex[k]}) return k;
    end
    return -1;
  endfunction

  task automatic do_reset(input logic link);
    @(negedge tx_clk);
    tx_reset_n = 1'b0;
    s_valid = 1'b0; s_last = 1'b0; s_error = 1'b0; s_data = 8'h00;
    link_up = link;
    repeat (3) @(negedge tx_clk);
    tx_reset_n = 1'b1;
  endtask

  task automatic send_frame(input bq_t pl, input int stop_at, input int link_drop_at, input int err_at);
    int i, guard, n;
    i = 0; guard = 0;
    n = (stop_at >= 0) ? stop_at : pl.size();
    while (i < n && guard < 4000) begin
      @(negedge tx_clk);
      s_data  = pl[i];
      s_last  = (stop_at < 0) && (i == n - 1);
      s_error = (i == err_at);
      s_valid = 1'b1;
      if (i == link_drop_at) link_up = 1'b0;
      if (s_ready) i++;
      guard++;
    end
    @(negedge tx_clk);
    s_valid = 1'b0; s_last = 1'b0; s_error = 1'b0; s_data = 8'h00;
    checks++;
    if (i != n) begin
      fails++;
      $display("FAIL handshake: accepted %0d bytes, required %0d", i, n);
    end
  endtask

  task automatic wait_fd(input int target);
    for (int k = 0; k < 600 && fd_cnt < target; k++) begin @(negedge tx_clk); #1; end
    repeat (16) begin @(negedge tx_clk); #1; end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({txd, tx_en, tx_er, frame_done, underrun, s_ready} !== 13'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %h required 0", {txd, tx_en, tx_er, frame_done, underrun, s_ready});
    end
    do_reset(1'b1);
    repeat (3) @(negedge tx_clk);
    #1;
    checks++;
    if ({tx_en, s_ready, cap.size()} !== {1'b0, 1'b0, 32'd0}) begin
      fails++;
      $display("FAIL reset_idle: tx_en=%b s_ready=%b beats=%0d required 0 0 0", tx_en, s_ready, cap.size());
    end
  endtask

  task automatic test_frame64();
    bq_t pl, ex;
    int b, b0, f0, u0, d;
    for (int k = 0; k < 64; k++) pl.push_back(8'(k));
    ex = build_frame(pl, 60);
    do_reset(1'b1);
    b = cap.size(); b0 = cap0.size(); f0 = fd_cnt; u0 = ur_cnt;
    send_frame(pl, -1, -1, -1);
    wait_fd(f0 + 1);
    checks++;
    if (cap.size() - b != 76) begin fails++; $display("FAIL frame64_len: got %0d required 76", cap.size() - b); end
    d = frame_diff(1'b0, b, ex, -1);
    checks++;
    if (d != -1) begin fails++; $display("FAIL frame64_bytes: first bad beat %0d required none", d); end
    checks++;
    if (fd_cnt - f0 != 1 || ur_cnt != u0) begin
      fails++; $display("FAIL frame64_pulses: frame_done=%0d underrun=%0d required 1 0", fd_cnt - f0, ur_cnt - u0);
    end
    checks++;
    if (fd_cyc != cap_cyc[cap.size() - 1] + 1) begin
      fails++; $display("FAIL frame64_done_timing: cycle %0d required %0d", fd_cyc, cap_cyc[cap.size() - 1] + 1);
    end
    d = frame_diff(1'b1, b0, ex, -1);
    checks++;
    if (d != -1 || cap0.size() - b0 != 76) begin fails++; $display("FAIL frame64_nopad_inst: first bad beat %0d len %0d required none 76", d, cap0.size() - b0); end
  endtask

  task automatic test_crc_check();
    bq_t pl, ex;
    logic [7:0] want[4];
    logic [8:0] got;
    int b, b0, f0, d;
    want = '{8'h26, 8'h39, 8'hF4, 8'hCB};
    for (int k = 0; k < 9; k++) pl.push_back(8'h31 + 8'(k));
    do_reset(1'b1);
    b = cap.size(); b0 = cap0.size(); f0 = fd_cnt;
    send_frame(pl, -1, -1, -1);
    wait_fd(f0 + 1);
    checks++;
    if (cap0.size() - b0 != 21) begin fails++; $display("FAIL crc_len: got %0d required 21", cap0.size() - b0); end
    for (int k = 0; k < 4; k++) begin
      got = (b0 + 17 + k < cap0.size()) ? cap0[b0 + 17 + k] : 9'h1FF;
      checks++;
      if (got !== {1'b0, want[k]}) begin fails++; $display("FAIL crc_fcs%0d: got %h required %h", k, got, want[k]); end
    end
    ex = build_frame(pl, 60);
    d = frame_diff(1'b0, b, ex, -1);
    checks++;
    if (d != -1 || cap.size() - b != 72) begin fails++; $display("FAIL crc_padded: first bad beat %0d len %0d required none 72", d, cap.size() - b); end
  endtask

  task automatic test_pad();
    bq_t pl, ex;
    int b, b0, f0, d, nz;
    for (int k = 0; k < 10; k++) pl.push_back(8'hA0 + 8'(k));
    ex = build_frame(pl, 60);
    do_reset(1'b1);
    b = cap.size(); b0 = cap0.size(); f0 = fd_cnt;
    send_frame(pl, -1, -1, -1);
    wait_fd(f0 + 1);
    checks++;
    if (cap.size() - b != 72) begin fails++; $display("FAIL pad_len: got %0d required 72", cap.size() - b); end
    nz = 0;
    for (int k = 18; k < 68; k++) if (b + k >= cap.size() || cap[b + k] !== 9'h000) nz++;
    checks++;
    if (nz != 0) begin fails++; $display("FAIL pad_zero: %0d nonzero pad beats required 0", nz); end
    d = frame_diff(1'b0, b, ex, -1);
    checks++;
    if (d != -1) begin fails++; $display("FAIL pad_bytes: first bad beat %0d required none", d); end
    checks++;
    if (cap0.size() - b0 != 22) begin fails++; $display("FAIL pad_disabled_len: got %0d required 22", cap0.size() - b0); end
  endtask

  task automatic test_underrun();
    bq_t pl, pl2, ex, ex2;
    int b, f0, u0, u00, d;
    for (int k = 0; k < 40; k++) pl.push_back(8'(3 * k + 1));
    for (int k = 0; k < 10; k++) pl2.push_back(8'hC0 ^ 8'(k));
    for (int k = 0; k < 7; k++) ex.push_back(8'h55);
    ex.push_back(8'hD5);
    for (int k = 0; k < 20; k++) ex.push_back(pl[k]);
    ex.push_back(8'h00);
    ex2 = build_frame(pl2, 60);
    do_reset(1'b1);
    b = cap.size(); f0 = fd_cnt; u0 = ur_cnt; u00 = ur0_cnt;
    send_frame(pl, 20, -1, -1);
    send_frame(pl2, -1, -1, -1);
    wait_fd(f0 + 1);
    d = frame_diff(1'b0, b, ex, 28);
    checks++;
    if (d != -1) begin fails++; $display("FAIL underrun_bytes: first bad beat %0d required none", d); end
    checks++;
    if (ur_cnt - u0 != 1 || ur0_cnt - u00 != 1) begin fails++; $display("FAIL underrun_pulse: got %0d/%0d required 1/1", ur_cnt - u0, ur0_cnt - u00); end
    checks++;
    if (cap.size() > b + 28 && ur_cyc != cap_cyc[b + 28]) begin fails++; $display("FAIL underrun_timing: cycle %0d required %0d", ur_cyc, cap_cyc[b + 28]); end
    checks++;
    if (fd_cnt - f0 != 1) begin fails++; $display("FAIL underrun_no_done: frame_done count %0d required 1 (second frame only)", fd_cnt - f0); end
    // Gap spans the 12 IFG cycles plus the IDLE cycle that launches the next frame.
    checks++;
    if (cap.size() < b + 30 || cap_cyc[b + 29] - cap_cyc[b + 28] != 14) begin
      fails++; $display("FAIL underrun_gap: beats %0d required idle gap 13", cap.size() - b);
    end
    d = frame_diff(1'b0, b + 29, ex2, -1);
    checks++;
    if (d != -1) begin fails++; $display("FAIL underrun_next_frame: first bad beat %0d required none", d); end
  endtask

  task automatic test_link();
    bq_t pl, ex;
    int b, f0, d, viol, k0;
    for (int k = 0; k < 30; k++) pl.push_back(8'h5A ^ 8'(k * 7));
    ex = build_frame(pl, 60);
    do_reset(1'b0);
    b = cap.size(); f0 = fd_cnt; viol = 0;
    @(negedge tx_clk);
    s_data = pl[0]; s_valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge tx_clk); #1;
      if (s_ready || s_ready0 || tx_en) viol++;
    end
    checks++;
    if (viol != 0 || cap.size() != b) begin fails++; $display("FAIL link_down_gate: %0d active cycles required 0", viol); end
    link_up = 1'b1;
    k0 = cyc;
    send_frame(pl, -1, 5, -1);
    wait_fd(f0 + 1);
    checks++;
    if (cap.size() <= b || cap_cyc[b] != k0 + 2) begin fails++; $display("FAIL link_up_start: first beat cycle %0d required %0d", (cap.size() > b) ? cap_cyc[b] : -1, k0 + 2); end
    checks++;
    if (link_up !== 1'b0 || cap.size() - b != 72) begin fails++; $display("FAIL link_drop_len: got %0d required 72", cap.size() - b); end
    d = frame_diff(1'b0, b, ex, -1);
    checks++;
    if (d != -1 || fd_cnt - f0 != 1) begin fails++; $display("FAIL link_drop_frame: first bad beat %0d done %0d required none 1", d, fd_cnt - f0); end
  endtask

  task automatic test_error();
    bq_t pl, ex;
    int b, f0, u0, d;
    for (int k = 0; k < 10; k++) pl.push_back(8'h10 + 8'(k));
    ex = build_frame(pl, 60);
    do_reset(1'b1);
    b = cap.size(); f0 = fd_cnt; u0 = ur_cnt;
    send_frame(pl, -1, -1, 9);
    wait_fd(f0 + 1);
    d = frame_diff(1'b0, b, ex, 17);
    checks++;
    if (d != -1 || cap.size() - b != 72) begin fails++; $display("FAIL error_frame: first bad beat %0d len %0d required none 72", d, cap.size() - b); end
    checks++;
    if (fd_cnt - f0 != 1 || ur_cnt != u0) begin fails++; $display("FAIL error_pulses: done %0d underrun %0d required 1 0", fd_cnt - f0, ur_cnt - u0); end
  endtask

  task automatic test_back_to_back();
    bq_t p1, p2, e1, e2;
    int b, f0, d;
    for (int k = 0; k < 10; k++) begin p1.push_back(8'(k * 17)); p2.push_back(8'hFF - 8'(k)); end
    e1 = build_frame(p1, 60);
    e2 = build_frame(p2, 60);
    do_reset(1'b1);
    b = cap.size(); f0 = fd_cnt;
    send_frame(p1, -1, -1, -1);
    send_frame(p2, -1, -1, -1);
    wait_fd(f0 + 2);
    checks++;
    if (fd_cnt - f0 != 2 || cap.size() - b != 144) begin fails++; $display("FAIL b2b_count: done %0d beats %0d required 2 144", fd_cnt - f0, cap.size() - b); end
    d = frame_diff(1'b0, b, e1, -1);
    checks++;
    if (d != -1) begin fails++; $display("FAIL b2b_first: first bad beat %0d required none", d); end
    d = frame_diff(1'b0, b + 72, e2, -1);
    checks++;
    if (d != -1) begin fails++; $display("FAIL b2b_second: first bad beat %0d required none", d); end
    checks++;
    if (cap.size() < b + 73 || cap_cyc[b + 72] - cap_cyc[b + 71] != 14) begin
      fails++; $display("FAIL b2b_ifg_gap: idle cycles %0d required 13", (cap.size() >= b + 73) ? cap_cyc[b + 72] - cap_cyc[b + 71] - 1 : -1);
    end
  endtask

  task automatic test_reset_fcs();
    bq_t pl, pl2, ex2;
    logic [31:0] fcs;
    int b, f0, d;
    for (int k = 0; k < 64; k++) pl.push_back(8'hFF - 8'(k));
    fcs = crc_model(pl);
    for (int k = 0; k < 9; k++) pl2.push_back(8'h31 + 8'(k));
    ex2 = build_frame(pl2, 60);
    do_reset(1'b1);
    b = cap.size(); f0 = fd_cnt;
    send_frame(pl, -1, -1, -1);
    for (int k = 0; k < 50 && cap.size() < b + 75; k++) begin @(negedge tx_clk); #1; end
    checks++;
    if (txd !== fcs[23:16] || tx_en !== 1'b1) begin fails++; $display("FAIL rst_fcs_pre: txd %h en %b required %h 1", txd, tx_en, fcs[23:16]); end
    tx_reset_n = 1'b0;
    #1;
    checks++;
    if ({tx_en, tx_er, txd} !== 10'h000) begin fails++; $display("FAIL rst_fcs_async: got %h required 0", {tx_en, tx_er, txd}); end
    repeat (2) @(negedge tx_clk);
    tx_reset_n = 1'b1;
    b = cap.size();
    send_frame(pl2, -1, -1, -1);
    wait_fd(f0 + 1);
    checks++;
    if (fd_cnt - f0 != 1) begin fails++; $display("FAIL rst_fcs_done: got %0d required 1", fd_cnt - f0); end
    d = frame_diff(1'b0, b, ex2, -1);
    checks++;
    if (d != -1 || cap.size() - b != 72) begin fails++; $display("FAIL rst_fcs_next: first bad beat %0d len %0d required none 72", d, cap.size() - b); end
  endtask

  initial begin
    test_reset();
    test_frame64();
    test_crc_check();
    test_pad();
    test_underrun();
    test_link();
    test_error();
    test_back_to_back();
    test_reset_fcs();
    checks++;
    if (both_cnt != 0) begin fails++; $display("FAIL pulse_exclusive: %0d overlapping cycles required 0", both_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

endmodule
